// File: rtl/actbuf_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// actbuf_wr_ctrl_if
//   Bundles the two word streams handled by actbuf_wr_ctrl:
//     - upstream source stream (valid/ready) that fills the elastic FIFO
//     - activation-buffer write port towards the sblk (req -> vld/data)
//
//   Signals
//     src_data       DATA_W  upstream word
//     src_vld        1       upstream word valid
//     src_rdy        1       controller FIFO can accept a word
//     actbuf_wr_req  1       sblk ready to take a word next cycle
//     actbuf_wr_vld  1       word on actbuf_wr_data is valid
//     actbuf_wr_data DATA_W  write data (IDLE_FILL when not valid)
//
//   Modports
//     master : the write controller (sinks src_*, drives actbuf_wr_vld/data)
//     slave  : the environment (upstream source plus sblk)
// ---------------------------------------------------------------------------
interface actbuf_wr_ctrl_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] src_data;
   logic              src_vld;
   logic              src_rdy;
   logic              actbuf_wr_req;
   logic              actbuf_wr_vld;
   logic [DATA_W-1:0] actbuf_wr_data;

   modport master (
      input  src_data,
      input  src_vld,
      input  actbuf_wr_req,
      output src_rdy,
      output actbuf_wr_vld,
      output actbuf_wr_data
   );

   modport slave (
      output src_data,
      output src_vld,
      output actbuf_wr_req,
      input  src_rdy,
      input  actbuf_wr_vld,
      input  actbuf_wr_data
   );
endinterface

// File: rtl/actbuf_wr_ctrl.sv
// ---------------------------------------------------------------------------
// actbuf_wr_ctrl
//   Transmitter side of the sblk_conv_row activation-buffer write interface.
//   Packed activation words arrive on a valid/ready stream, are held in a
//   small elastic FIFO and are handed to the sblk one word per cycle, one
//   cycle after the sblk requests them. Traffic is framed into rows of
//   cfg_words words; between rows the controller waits for a rising edge
//   of sblk_status (synchronised locally, it may come from clk_h).
//
//   Ports
//     clk_l        in   clock
//     rst_n        in   asynchronous active-low reset
//     cfg_en       in   start pulse, latches cfg_words/cfg_rows when idle
//     cfg_words    in   words per row
//     cfg_rows     in   rows per job
//     bus          if   src_* stream and actbuf_wr_* port (master view)
//     sblk_status  in   sblk row-complete level
//     busy         out  job in progress
//     done         out  one-cycle pulse at job end
//     stall_cnt    out  saturating count of cycles starved by an empty FIFO
// ---------------------------------------------------------------------------
module actbuf_wr_ctrl #(
   parameter int                DATA_W     = 32,
   parameter int                CNT_W      = 16,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [DATA_W-1:0] IDLE_FILL  = {DATA_W{1'b1}}
) (
   input  logic                 clk_l,
   input  logic                 rst_n,
   input  logic                 cfg_en,
   input  logic [CNT_W-1:0]     cfg_words,
   input  logic [CNT_W-1:0]     cfg_rows,
   actbuf_wr_ctrl_if.master     bus,
   input  logic                 sblk_status,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam int             AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_WAIT,
      ST_DONE
   } state_t;

   // Counter that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t              state_q;
   logic [CNT_W-1:0]    cfg_words_q;
   logic [CNT_W-1:0]    cfg_rows_q;
   logic [CNT_W-1:0]    word_cnt_q;
   logic [CNT_W-1:0]    row_cnt_q;
   logic [CNT_W-1:0]    stall_q;
   logic                busy_q;
   logic                done_q;
   logic                vld_q;
   logic [DATA_W-1:0]   data_q;

   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q;
   logic [AW-1:0]       rd_ptr_q;
   logic [AW:0]         count_q;

   logic                status_meta_q;
   logic                status_sync_q;
   logic                status_dly_q;

   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                issue_d;
   logic [DATA_W-1:0]   wr_data_d;
   logic                status_rise;
   logic                stall_hit;

   assign fifo_full   = (count_q == DEPTH_C);
   assign fifo_empty  = (count_q == '0);
   assign bus.src_rdy = ~fifo_full;
   assign push        = bus.src_vld & ~fifo_full;

   // A word leaves only when the sblk asked for it, the row still has room
   // and something is buffered; the pop happens on the same edge that
   // registers vld, so req-to-vld latency is exactly one cycle.
   assign issue_d   = bus.actbuf_wr_req & (state_q == ST_STREAM) & ~fifo_empty
                    & (word_cnt_q < cfg_words_q);
   assign wr_data_d = issue_d ? mem_q[rd_ptr_q] : IDLE_FILL;

   assign stall_hit   = bus.actbuf_wr_req & (state_q == ST_STREAM) & fifo_empty;
   assign status_rise = status_sync_q & ~status_dly_q;

   // ---- sblk_status synchroniser + edge detect ----
   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         status_meta_q <= 1'b0;
         status_sync_q <= 1'b0;
         status_dly_q  <= 1'b0;
      end else begin
         status_meta_q <= sblk_status;
         status_sync_q <= status_meta_q;
         status_dly_q  <= status_sync_q;
      end
   end

   // ---- elastic FIFO: storage (data only, not reset) ----
   always_ff @(posedge clk_l) begin
      if (push) mem_q[wr_ptr_q] <= bus.src_data;
   end

   // ---- elastic FIFO: pointers and occupancy ----
   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
         if (issue_d) rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, issue_d})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   // ---- framing FSM and registered write port ----
   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cfg_words_q <= '0;
         cfg_rows_q  <= '0;
         word_cnt_q  <= '0;
         row_cnt_q   <= '0;
         stall_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         vld_q       <= 1'b0;
         data_q      <= IDLE_FILL;
      end else begin
         vld_q  <= issue_d;
         data_q <= wr_data_d;
         done_q <= 1'b0;
         if (stall_hit) stall_q <= sat_inc(stall_q);

         unique case (state_q)
            ST_IDLE: begin
               if (cfg_en) begin
                  cfg_words_q <= cfg_words;
                  cfg_rows_q  <= cfg_rows;
                  word_cnt_q  <= '0;
                  row_cnt_q   <= '0;
                  stall_q     <= '0;
                  busy_q      <= 1'b1;
                  // An empty job still produces its done pulse.
                  if ((cfg_words == '0) || (cfg_rows == '0)) state_q <= ST_DONE;
                  else                                       state_q <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (issue_d) begin
                  if (word_cnt_q == cfg_words_q - 1'b1) begin
                     word_cnt_q <= '0;
                     state_q    <= ST_WAIT;
                  end else begin
                     word_cnt_q <= word_cnt_q + 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (status_rise) begin
                  if (row_cnt_q + 1'b1 == cfg_rows_q) begin
                     state_q <= ST_DONE;
                  end else begin
                     row_cnt_q <= row_cnt_q + 1'b1;
                     state_q   <= ST_STREAM;
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.actbuf_wr_vld  = vld_q;
   assign bus.actbuf_wr_data = data_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign stall_cnt          = stall_q;

endmodule
